// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM/WB results into the two register
// read operands, detects the load-use hazard, and registers operands,
// immediate, indices and control into the ID/EX latch.
// Optional feature macro: ID_EX_STALL_CNT_EN adds a 32-bit StallCount
// output that counts every cycle on which Stall is asserted.
module id_ex_operand_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int CTRL_W   = 10,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IdValid,
    input  logic [REG_W-1:0]  IdSrc1,
    input  logic [REG_W-1:0]  IdSrc2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [REG_W-1:0]  IdDst,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic [CTRL_W-1:0] IdCtrl,
    input  logic [DATA_W-1:0] ExAluResult,
    input  logic              MemFwdValid,
    input  logic [REG_W-1:0]  MemFwdDst,
    input  logic [DATA_W-1:0] MemFwdData,
    input  logic              WbRegWrite,
    input  logic [REG_W-1:0]  WbDst,
    input  logic [DATA_W-1:0] WbData,
    input  logic              Flush,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       StallCount,
`endif
    output logic              Stall,
    output logic              ExValid,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic [DATA_W-1:0] ExA,
    output logic [DATA_W-1:0] ExB,
    output logic [DATA_W-1:0] ExImm,
    output logic [REG_W-1:0]  ExDst,
    output logic [REG_W-1:0]  ExSrc1,
    output logic [REG_W-1:0]  ExSrc2,
    output logic [CTRL_W-1:0] ExCtrl
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    // ID/EX latch state and its next-state values
    logic              valid_q,     valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  dst_q,  dst_d;
    logic [REG_W-1:0]  src1_q, src1_d;
    logic [REG_W-1:0]  src2_q, src2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              ex_fwd_ok;
    logic              load_in_ex;
    logic              hazard;
    logic              stall;

    // EX can forward only a completed ALU result; a load's data is not ready yet
    assign ex_fwd_ok  = valid_q && reg_write_q && !mem_read_q;
    assign load_in_ex = valid_q && mem_read_q;

    assign hazard = load_in_ex &&
                    (((IdSrc1 != ZERO_IDX) && (dst_q == IdSrc1)) ||
                     ((IdSrc2 != ZERO_IDX) && (dst_q == IdSrc2)));

    // Flush and reset both suppress the stall so the front end is never held by a squashed instruction
    assign stall = !reset && !Flush && IdValid && hazard;
    assign Stall = stall;

    // Forwarding mux per source: zero register, then youngest producer first
    always_comb begin
        if (IdSrc1 == ZERO_IDX)                           op_a = '0;
        else if (ex_fwd_ok && dst_q == IdSrc1)            op_a = ExAluResult;
        else if (MemFwdValid && MemFwdDst == IdSrc1)      op_a = MemFwdData;
        else if (WbRegWrite && WbDst == IdSrc1)           op_a = WbData;
        else                                              op_a = ReadData1;

        if (IdSrc2 == ZERO_IDX)                           op_b = '0;
        else if (ex_fwd_ok && dst_q == IdSrc2)            op_b = ExAluResult;
        else if (MemFwdValid && MemFwdDst == IdSrc2)      op_b = MemFwdData;
        else if (WbRegWrite && WbDst == IdSrc2)           op_b = WbData;
        else                                              op_b = ReadData2;
    end

    // Latch next state: ID values normally, a control-only bubble on stall or flush
    always_comb begin
        // NOTE: every _d gets a value before any branch so no path can infer a latch.
        valid_d     = IdValid;
        reg_write_d = IdValid && IdRegWrite;
        mem_read_d  = IdValid && IdMemRead;
        ctrl_d      = IdValid ? IdCtrl : '0;
        a_d         = op_a;
        b_d         = op_b;
        imm_d       = IdImm;
        dst_d       = IdDst;
        src1_d      = IdSrc1;
        src2_d      = IdSrc2;
        if (Flush || stall) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ctrl_d      = '0;
        end
    end

    // ID/EX pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            ctrl_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            dst_q       <= dst_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign ExValid    = valid_q;
    assign ExRegWrite = reg_write_q;
    assign ExMemRead  = mem_read_q;
    assign ExA        = a_q;
    assign ExB        = b_q;
    assign ExImm      = imm_q;
    assign ExDst      = dst_q;
    assign ExSrc1     = src1_q;
    assign ExSrc2     = src2_q;
    assign ExCtrl     = ctrl_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Free-running stall counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset)      stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: each test task drives one ID
// cycle, pushes the expected latch contents, and the popped entry is
// compared against the Ex* outputs one clock later.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IdValid;
    logic [4:0]  IdSrc1, IdSrc2, IdDst;
    logic [63:0] ReadData1, ReadData2, IdImm;
    logic        IdRegWrite, IdMemRead;
    logic [9:0]  IdCtrl;
    logic [63:0] ExAluResult;
    logic        MemFwdValid;
    logic [4:0]  MemFwdDst;
    logic [63:0] MemFwdData;
    logic        WbRegWrite;
    logic [4:0]  WbDst;
    logic [63:0] WbData;
    logic        Flush;
    logic        Stall, ExValid, ExRegWrite, ExMemRead;
    logic [63:0] ExA, ExB, ExImm;
    logic [4:0]  ExDst, ExSrc1, ExSrc2;
    logic [9:0]  ExCtrl;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] StallCount;
`endif

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .IdValid(IdValid),
        .IdSrc1(IdSrc1), .IdSrc2(IdSrc2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .IdImm(IdImm), .IdDst(IdDst), .IdRegWrite(IdRegWrite),
        .IdMemRead(IdMemRead), .IdCtrl(IdCtrl),
        .ExAluResult(ExAluResult),
        .MemFwdValid(MemFwdValid), .MemFwdDst(MemFwdDst), .MemFwdData(MemFwdData),
        .WbRegWrite(WbRegWrite), .WbDst(WbDst), .WbData(WbData),
        .Flush(Flush),
`ifdef ID_EX_STALL_CNT_EN
        .StallCount(StallCount),
`endif
        .Stall(Stall), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExA(ExA), .ExB(ExB), .ExImm(ExImm),
        .ExDst(ExDst), .ExSrc1(ExSrc1), .ExSrc2(ExSrc2), .ExCtrl(ExCtrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          valid, rw, mr;
        bit          chk_data;
        logic [63:0] a, b, imm;
        logic [4:0]  dst, s1, s2;
        logic [9:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic exp_t mk(bit stall, bit valid, bit rw, bit mr, logic [9:0] ctrl,
                                logic [63:0] a, logic [63:0] b, logic [63:0] imm,
                                logic [4:0] dst, logic [4:0] s1, logic [4:0] s2);
        exp_t e;
        e.stall = stall; e.valid = valid; e.rw = rw; e.mr = mr; e.ctrl = ctrl;
        e.chk_data = 1'b1; e.a = a; e.b = b; e.imm = imm;
        e.dst = dst; e.s1 = s1; e.s2 = s2;
        return e;
    endfunction

    function automatic exp_t bubble(bit stall);
        exp_t e;
        e = mk(stall, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        e.chk_data = 1'b0;
        return e;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; IdValid = 1'b0; IdSrc1 = 5'd0; IdSrc2 = 5'd0; IdDst = 5'd0;
        ReadData1 = '0; ReadData2 = '0; IdImm = '0; IdRegWrite = 1'b0;
        IdMemRead = 1'b0; IdCtrl = '0; ExAluResult = '0; MemFwdValid = 1'b0;
        MemFwdDst = 5'd0; MemFwdData = '0; WbRegWrite = 1'b0; WbDst = 5'd0;
        WbData = '0; Flush = 1'b0;
    endtask

    task automatic set_id(logic [4:0] s1, logic [4:0] s2, logic [63:0] rd1, logic [63:0] rd2,
                          logic [63:0] imm, logic [4:0] dst, bit rw, bit mr, logic [9:0] ctrl);
        IdValid = 1'b1; IdSrc1 = s1; IdSrc2 = s2; ReadData1 = rd1; ReadData2 = rd2;
        IdImm = imm; IdDst = dst; IdRegWrite = rw; IdMemRead = mr; IdCtrl = ctrl;
    endtask

    // Called at a negedge with inputs applied: checks Stall, clocks, then checks the latch.
    task automatic step(input string name, input exp_t e);
        exp_t x;
        #1;
        n_vec++;
        if (Stall !== e.stall) begin
            n_miss++;
            $display("FAIL %s stall: got %b want %b", name, Stall, e.stall);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        n_vec++;
        if ({ExValid, ExRegWrite, ExMemRead} !== {x.valid, x.rw, x.mr}) begin
            n_miss++;
            $display("FAIL %s ctl: got v/rw/mr=%b%b%b want %b%b%b", name,
                     ExValid, ExRegWrite, ExMemRead, x.valid, x.rw, x.mr);
        end
        n_vec++;
        if (ExCtrl !== x.ctrl) begin
            n_miss++;
            $display("FAIL %s ExCtrl: got %h want %h", name, ExCtrl, x.ctrl);
        end
        if (x.chk_data) begin
            n_vec++;
            if (ExA !== x.a) begin
                n_miss++;
                $display("FAIL %s ExA: got %h want %h", name, ExA, x.a);
            end
            n_vec++;
            if (ExB !== x.b) begin
                n_miss++;
                $display("FAIL %s ExB: got %h want %h", name, ExB, x.b);
            end
            n_vec++;
            if (ExImm !== x.imm) begin
                n_miss++;
                $display("FAIL %s ExImm: got %h want %h", name, ExImm, x.imm);
            end
            n_vec++;
            if ({ExDst, ExSrc1, ExSrc2} !== {x.dst, x.s1, x.s2}) begin
                n_miss++;
                $display("FAIL %s idx: got %0d/%0d/%0d want %0d/%0d/%0d", name,
                         ExDst, ExSrc1, ExSrc2, x.dst, x.s1, x.s2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            reset = 1'b1;
            set_id(5'd1, 5'd2, 64'h5, 64'h7, 64'h9, 5'd4, 1'b1, 1'b1, 10'h3ff);
            step("reset", mk(0, 0, 0, 0, '0, '0, '0, '0, '0, '0, '0));
        end
    endtask

    task automatic test_normal();
        idle_inputs();
        set_id(5'd1, 5'd2, 64'd5, 64'd7, 64'h123, 5'd4, 1'b1, 1'b0, 10'h155);
        step("normal", mk(0, 1, 1, 0, 10'h155, 64'd5, 64'd7, 64'h123, 5'd4, 5'd1, 5'd2));
        // IdValid low must zero the control even with writes requested
        idle_inputs();
        set_id(5'd6, 5'd7, 64'hA, 64'hB, 64'h1, 5'd8, 1'b1, 1'b1, 10'h2aa);
        IdValid = 1'b0;
        step("id_invalid", bubble(0));
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        set_id(5'd2, 5'd3, 64'h0, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 10'h001);
        step("fwd_prod", mk(0, 1, 1, 0, 10'h001, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd3));
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            set_id(5'd1, 5'd2, 64'h11, 64'h22, 64'h0, 5'd5, 1'b0, 1'b0, 10'h002);
            ExAluResult = 64'd9;
            MemFwdValid = (k < 2); MemFwdDst = 5'd1; MemFwdData = 64'd8;
            WbRegWrite  = (k < 3); WbDst = 5'd1;     WbData = 64'd6;
            case (k)
                0: step("fwd_ex",  mk(0, 1, 0, 0, 10'h002, 64'd9,  64'h22, 64'h0, 5'd5, 5'd1, 5'd2));
                1: step("fwd_mem", mk(0, 1, 0, 0, 10'h002, 64'd8,  64'h22, 64'h0, 5'd5, 5'd1, 5'd2));
                2: step("fwd_wb",  mk(0, 1, 0, 0, 10'h002, 64'd6,  64'h22, 64'h0, 5'd5, 5'd1, 5'd2));
                default: step("fwd_rf", mk(0, 1, 0, 0, 10'h002, 64'h11, 64'h22, 64'h0, 5'd5, 5'd1, 5'd2));
            endcase
        end
        // Operand B forwards independently from MEM
        idle_inputs();
        set_id(5'd9, 5'd10, 64'h99, 64'hAA, 64'h0, 5'd0, 1'b0, 1'b0, 10'h0);
        MemFwdValid = 1'b1; MemFwdDst = 5'd10; MemFwdData = 64'hBEEF;
        step("fwd_b_mem", mk(0, 1, 0, 0, 10'h0, 64'h99, 64'hBEEF, 64'h0, 5'd0, 5'd9, 5'd10));
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h8, 5'd3, 1'b1, 1'b1, 10'h010);
        step("ldur", mk(0, 1, 1, 1, 10'h010, 64'h0, 64'h0, 64'h8, 5'd3, 5'd0, 5'd0));
        idle_inputs();
        set_id(5'd3, 5'd4, 64'h33, 64'h4444, 64'h0, 5'd6, 1'b1, 1'b0, 10'h020);
        ExAluResult = 64'hDEAD;
        step("lu_stall", bubble(1));
        idle_inputs();
        set_id(5'd3, 5'd4, 64'h33, 64'h4444, 64'h0, 5'd6, 1'b1, 1'b0, 10'h020);
        MemFwdValid = 1'b1; MemFwdDst = 5'd3; MemFwdData = 64'h44;
        step("lu_replay", mk(0, 1, 1, 0, 10'h020, 64'h44, 64'h4444, 64'h0, 5'd6, 5'd3, 5'd4));
        // Hazard through source 2
        idle_inputs();
        set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 5'd7, 1'b1, 1'b1, 10'h0);
        step("ldur2", mk(0, 1, 1, 1, 10'h0, 64'h0, 64'h0, 64'h0, 5'd7, 5'd0, 5'd0));
        idle_inputs();
        set_id(5'd1, 5'd7, 64'h0, 64'h0, 64'h0, 5'd2, 1'b1, 1'b0, 10'h0);
        step("lu_src2", bubble(1));
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 5'd31, 1'b1, 1'b0, 10'h0);
        step("x31_alu", mk(0, 1, 1, 0, 10'h0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd0, 5'd0));
        idle_inputs();
        set_id(5'd31, 5'd31, 64'hFF, 64'hFF, 64'h0, 5'd31, 1'b1, 1'b1, 10'h0);
        ExAluResult = 64'hFF;
        MemFwdValid = 1'b1; MemFwdDst = 5'd31; MemFwdData = 64'hFF;
        WbRegWrite  = 1'b1; WbDst = 5'd31;     WbData = 64'hFF;
        step("x31_read", mk(0, 1, 1, 1, 10'h0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31));
        // EX now holds a load to X31: reading X31 must not stall
        idle_inputs();
        set_id(5'd31, 5'd31, 64'hFF, 64'hFF, 64'h0, 5'd1, 1'b0, 1'b0, 10'h0);
        step("x31_nohaz", mk(0, 1, 0, 0, 10'h0, 64'h0, 64'h0, 64'h0, 5'd1, 5'd31, 5'd31));
    endtask

    task automatic test_flush();
        idle_inputs();
        set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 5'd3, 1'b1, 1'b1, 10'h0);
        step("fl_ldur", mk(0, 1, 1, 1, 10'h0, 64'h0, 64'h0, 64'h0, 5'd3, 5'd0, 5'd0));
        idle_inputs();
        set_id(5'd3, 5'd3, 64'h0, 64'h0, 64'h0, 5'd2, 1'b1, 1'b0, 10'h3ff);
        Flush = 1'b1;
        step("fl_haz", bubble(0));
        idle_inputs();
        set_id(5'd1, 5'd2, 64'h5, 64'h6, 64'h0, 5'd2, 1'b1, 1'b1, 10'h3ff);
        Flush = 1'b1;
        step("fl_plain", bubble(0));
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 5'd3, 1'b1, 1'b1, 10'h0);
        step("rs_ldur", mk(0, 1, 1, 1, 10'h0, 64'h0, 64'h0, 64'h0, 5'd3, 5'd0, 5'd0));
        idle_inputs();
        set_id(5'd3, 5'd4, 64'h7, 64'h8, 64'h9, 5'd5, 1'b1, 1'b0, 10'h1);
        reset = 1'b1;
        step("rs_mid", mk(0, 0, 0, 0, '0, '0, '0, '0, '0, '0, '0));
    endtask

    task automatic test_back_to_back_stalls();
        idle_inputs();
        reset = 1'b1;
        step("cnt_rst", mk(0, 0, 0, 0, '0, '0, '0, '0, '0, '0, '0));
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            set_id(5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 5'd3, 1'b1, 1'b1, 10'h0);
            step("cnt_ldur", mk(0, 1, 1, 1, 10'h0, 64'h0, 64'h0, 64'h0, 5'd3, 5'd0, 5'd0));
            idle_inputs();
            set_id(5'd3, 5'd0, 64'h0, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 10'h0);
            step("cnt_stall", bubble(1));
        end
`ifdef ID_EX_STALL_CNT_EN
        n_vec++;
        if (StallCount !== 32'd3) begin
            n_miss++;
            $display("FAIL stall_count: got %0d want 3", StallCount);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_normal();
        test_forward_priority();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back_stalls();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
